ysyx_041461_div_seq: RTL and testbench
======================================

Name: ysyx_041461_div_seq

Overview:
Multi-cycle iterative divider sequencer that replaces the single-cycle combinational DIV/DIVU/REM/REMU and W-variant paths in the execute stage. It accepts one operation via a valid/ready handshake and runs a radix-2 restoring-division FSM, one quotient bit per cycle. It presents the result through an output valid/ready handshake. The execute stage stalls on div_ready/div_busy, and the pipeline flush kills an in-flight operation.

Parameters:
XLEN, 64, full operand/result width
WLEN, 32, operand width for W-variant ops (DIVW/DIVUW/REMW/REMUW)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
div_valid_in  in  1  operation request valid
div_ready  out  1  sequencer can accept request (state IDLE)
div_op  in  3  [0]=signed, [1]=remainder (else quotient), [2]=word (32-bit)
div_src1  in  64  dividend
div_src2  in  64  divisor
div_flush  in  1  pipeline flush; kill current op
div_out_valid  out  1  result valid (state DONE)
div_out_ready  in  1  consumer accepts result
div_out  out  64  result, final 64-bit form
div_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; div_out=0, div_out_valid=0, div_busy=0, div_ready=1; iteration counter, remainder, quotient and operand registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - div_ready=1.
  - Accept when div_valid_in && div_ready && !div_flush. Latch op, operands and sign flags.
  - Word ops use src[31:0]; signed ops sign-extend to 32 bits first.
- Special cases, decided at accept:
  - Divisor==0: go directly to DONE. Quotient = all ones. Remainder = dividend (word ops: sign-extended 32-bit dividend).
  - Signed overflow: dividend = most-negative value of the op width and divisor = -1. Go directly to DONE. Quotient = dividend, remainder = 0.
  - Result in both special cases is ready in the cycle after accept.
- Normal path:
  - Operands converted to magnitudes for signed ops. Counter loaded with N-1, where N=64 (XLEN) or 32 (WLEN).
  - CALC performs one shift-subtract step per cycle. Counter decrements each step; after the step with counter==0, go to DONE.
  - Latency: accept at edge T, div_out_valid high from edge T+N+1.
- Result correction, applied on entry to DONE:
  - Quotient negated if sign(dividend) XOR sign(divisor), signed ops only.
  - Remainder negated if sign(dividend), signed ops only.
  - Word ops: the 32-bit result is sign-extended to 64 bits, including DIVUW/REMUW.
- DONE:
  - div_out_valid=1 and div_out stable.
  - Leave to IDLE when div_out_ready=1. div_out_ready=0 holds the result indefinitely.
  - No new accept in DONE (div_ready=0).
- div_flush, synchronous, highest priority:
  - In any state, next state = IDLE and div_out_valid drops next cycle. The result is discarded.
  - An accept is suppressed in the flush cycle.
- Simultaneous flush and div_out_ready in DONE: flush wins, with the same next state (IDLE).
- Reset mid-operation: immediate IDLE, no partial result visible.
- div_out holds its last value outside DONE. Consumers use div_out_valid only.

Decomposition:
- Shared macro file (`ysyx_041461_macro.v`):
  - div_op bit positions.
  - State encodings `ysyx_041461_DIV_IDLE/CALC/DONE`.
  - Iteration counts 64/32.
- Sub-module `ysyx_041461_div_step`: one combinational restoring step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit.
- FSM, counter, sign handling and result correction stay in the top module.

Test Plan:
- DIVU (op=000), 100/7:
  - div_out=14, valid exactly 65 cycles after accept.
  - Then REMU (op=010) 100/7 -> 2.
- DIV (op=001), src1=-7, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3).
- REM (op=011), same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero:
  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REMW (op=111) 0x0000_0000_8000_0001/0 -> 0xFFFF_FFFF_8000_0001.
  - Both one cycle after accept.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REMW 0x8000_0000 / 0xFFFF_FFFF -> 0.
  - Both one cycle after accept.
- DIVUW (op=100), 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF, valid 33 cycles after accept.
- Flush and backpressure:
  - Assert div_flush 10 cycles into a DIVU -> IDLE next cycle, no div_out_valid pulse.
  - New DIVU 9/3 -> 3.
  - Hold div_out_ready=0 for 5 cycles in DONE -> div_out_valid and div_out stay stable; one transfer when released.

Source files
------------

// File: rtl/ysyx_041461_div_seq_pkg.sv
//==============================================================================
// Module      : ysyx_041461_div_seq_pkg
// Description : Shared types and constants for the iterative divider sequencer:
//               op-field bit positions, default widths and FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ysyx_041461_div_seq_pkg;

    // Default operand widths (full and word-variant)
    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;

    // div_op bit positions
    localparam int OP_SIGNED = 0;
    localparam int OP_REM    = 1;
    localparam int OP_WORD   = 2;

    // Sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_041461_div_seq_if.sv
//==============================================================================
// Module      : ysyx_041461_div_seq_if
// Description : Request/response handshake bundle between the execute stage
//               (master) and the iterative divider (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ysyx_041461_div_seq_if
    import ysyx_041461_div_seq_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
);
    logic            div_valid_in;
    logic            div_ready;
    logic [2:0]      div_op;
    logic [XLEN-1:0] div_src1;
    logic [XLEN-1:0] div_src2;
    logic            div_flush;
    logic            div_out_valid;
    logic            div_out_ready;
    logic [XLEN-1:0] div_out;
    logic            div_busy;

    modport master (
        output div_valid_in, div_op, div_src1, div_src2, div_flush, div_out_ready,
        input  div_ready, div_out_valid, div_out, div_busy
    );

    modport slave (
        input  div_valid_in, div_op, div_src1, div_src2, div_flush, div_out_ready,
        output div_ready, div_out_valid, div_out, div_busy
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_041461_div_step.sv
//==============================================================================
// Module      : ysyx_041461_div_step
// Description : One combinational radix-2 restoring division step: shift the
//               next dividend bit into the partial remainder and subtract the
//               divisor if it fits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_041461_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;

    // Partial remainder is always below the divisor, so the trial value fits in
    // XLEN+1 bits and the top bit of the difference is a clean borrow flag.
    assign w_trial = {rem_in, dvd_bit};
    assign w_diff  = w_trial - {1'b0, divisor};
    assign q_bit   = ~w_diff[XLEN];
    assign rem_out = q_bit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/ysyx_041461_div_seq.sv
//==============================================================================
// Module      : ysyx_041461_div_seq
// Description : Multi-cycle DIV/DIVU/REM/REMU (+W variants) sequencer. Accepts
//               one op, iterates one quotient bit per cycle, applies sign
//               correction and holds the result until the consumer takes it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_041461_div_seq
    import ysyx_041461_div_seq_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int WLEN = DIV_WLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_041461_div_seq_if.slave div_if
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_xmin  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_wmin  = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    localparam logic [CW-1:0]   c_cnt_x = CW'(XLEN-1);
    localparam logic [CW-1:0]   c_cnt_w = CW'(WLEN-1);

    div_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [XLEN-1:0] r_dsr;
    logic            r_word;
    logic            r_rem_sel;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_out;

    logic            w_sgn, w_word, w_rem;
    logic [XLEN-1:0] w_a_sx, w_b_sx, w_a, w_b, w_a_mag, w_b_mag, w_spec;
    logic            w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [XLEN-1:0] w_rem_nxt, w_dvd_nxt, w_q_raw, w_sel, w_cor, w_final;
    logic            w_q_bit, w_neg;

    // Operand decode at accept: word ops take the low half, sign-extended for
    // signed ops and for the special-case results, zero-extended otherwise.
    assign w_sgn    = div_if.div_op[OP_SIGNED];
    assign w_rem    = div_if.div_op[OP_REM];
    assign w_word   = div_if.div_op[OP_WORD];
    assign w_a_sx   = w_word ? {{(XLEN-WLEN){div_if.div_src1[WLEN-1]}}, div_if.div_src1[WLEN-1:0]}
                             : div_if.div_src1;
    assign w_b_sx   = w_word ? {{(XLEN-WLEN){div_if.div_src2[WLEN-1]}}, div_if.div_src2[WLEN-1:0]}
                             : div_if.div_src2;
    assign w_a      = (w_word && !w_sgn) ? {{(XLEN-WLEN){1'b0}}, div_if.div_src1[WLEN-1:0]} : w_a_sx;
    assign w_b      = (w_word && !w_sgn) ? {{(XLEN-WLEN){1'b0}}, div_if.div_src2[WLEN-1:0]} : w_b_sx;
    assign w_a_neg  = w_sgn & w_a[XLEN-1];
    assign w_b_neg  = w_sgn & w_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a : w_a;
    assign w_b_mag  = w_b_neg ? -w_b : w_b;
    assign w_b_zero = (w_b == '0);
    assign w_ovf    = w_sgn & (w_b == '1) & (w_a == (w_word ? c_wmin : c_xmin));
    assign w_spec   = w_b_zero ? (w_rem ? w_a_sx : '1) : (w_rem ? '0 : w_a_sx);

    ysyx_041461_div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (r_rem),
        .dvd_bit (r_dvd[XLEN-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_nxt),
        .q_bit   (w_q_bit)
    );

    // Result correction is computed from the post-step values so the final
    // iteration can land the corrected result directly in r_out.
    assign w_dvd_nxt = {r_dvd[XLEN-2:0], w_q_bit};
    assign w_q_raw   = r_word ? {{(XLEN-WLEN){1'b0}}, w_dvd_nxt[WLEN-1:0]} : w_dvd_nxt;
    assign w_sel     = r_rem_sel ? w_rem_nxt : w_q_raw;
    assign w_neg     = r_rem_sel ? r_neg_r : r_neg_q;
    assign w_cor     = w_neg ? -w_sel : w_sel;
    assign w_final   = r_word ? {{(XLEN-WLEN){w_cor[WLEN-1]}}, w_cor[WLEN-1:0]} : w_cor;

    // Sequencer FSM: flush overrides everything, special cases skip CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_word    <= 1'b0;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_out     <= '0;
        end else if (div_if.div_flush) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (div_if.div_valid_in) begin
                        r_word    <= w_word;
                        r_rem_sel <= w_rem;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        if (w_b_zero || w_ovf) begin
                            r_out   <= w_spec;
                            r_state <= DIV_DONE;
                        end else begin
                            r_dvd   <= w_word ? {w_a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : w_a_mag;
                            r_dsr   <= w_b_mag;
                            r_rem   <= '0;
                            r_cnt   <= w_word ? c_cnt_w : c_cnt_x;
                            r_state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    if (r_cnt == '0) begin
                        r_out   <= w_final;
                        r_state <= DIV_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (div_if.div_out_ready) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign div_if.div_ready     = (r_state == DIV_IDLE);
    assign div_if.div_busy      = (r_state != DIV_IDLE);
    assign div_if.div_out_valid = (r_state == DIV_DONE);
    assign div_if.div_out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_041461_div_seq.sv
//==============================================================================
// Module      : tb_ysyx_041461_div_seq
// Description : Scoreboard bench for the iterative divider: directed cases with
//               fixed expected values plus randomized ops against an arithmetic
//               reference model; a separate monitor consumes results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ysyx_041461_div_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_041461_div_seq_if #(.XLEN(64)) dif ();

    ysyx_041461_div_seq #(.XLEN(64), .WLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    typedef struct {
        logic [63:0] exp;
        int          lat;
        int          acc;
        int          hold;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   n_sent = 0;

    // Cycle count, advanced on the active edge and read on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, id, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain arithmetic.
    // Latency counts from the cycle the request is presented.
    function automatic void ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] res, output int lat);
        logic        sgn;
        logic        remf;
        int          sa, sb32;
        int unsigned ua, ub;
        longint      la, lb;
        logic [31:0] r32;
        sgn  = op[0];
        remf = op[1];
        if (op[2]) begin
            ua   = a[31:0];
            ub   = b[31:0];
            sa   = int'(ua);
            sb32 = int'(ub);
            if (ub == 0) begin
                r32 = remf ? ua : 32'hFFFF_FFFF;
                lat = 1;
            end else if (sgn && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
                r32 = remf ? 32'h0 : ua;
                lat = 1;
            end else begin
                lat = 33;
                if (sgn) r32 = remf ? 32'(sa % sb32) : 32'(sa / sb32);
                else     r32 = remf ? (ua % ub) : (ua / ub);
            end
            res = {{32{r32[31]}}, r32};
        end else begin
            la = longint'(a);
            lb = longint'(b);
            if (b == 64'h0) begin
                res = remf ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                res = remf ? 64'h0 : a;
                lat = 1;
            end else begin
                lat = 65;
                if (sgn) res = remf ? 64'(la % lb) : 64'(la / lb);
                else     res = remf ? (a % b) : (a / b);
            end
        end
    endfunction

    // Monitor/consumer: pops one expectation per result, optionally holding
    // div_out_ready low for the requested number of cycles first.
    bit          seen = 0;
    bit          gone = 0;
    int          hold_n = 0;
    logic [63:0] held;
    always @(negedge clk) begin
        if (rst) begin
            dif.div_out_ready = 1'b0;
            seen = 0;
            gone = 0;
        end else begin
            if (gone) begin
                chk("valid_drop_after_xfer", 0, {63'b0, dif.div_out_valid}, 64'd0);
                gone = 0;
            end
            if (dif.div_out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid got=%0h expected=no_result", dif.div_out);
                end else begin
                    if (!seen) begin
                        seen   = 1;
                        hold_n = 0;
                        held   = dif.div_out;
                        chk("latency", sb[0].id, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    end else begin
                        chk("hold_stable", sb[0].id, dif.div_out, held);
                    end
                    if (hold_n < sb[0].hold) begin
                        hold_n++;
                        dif.div_out_ready = 1'b0;
                    end else begin
                        chk("result", sb[0].id, dif.div_out, sb[0].exp);
                        void'(sb.pop_front());
                        dif.div_out_ready = 1'b1;
                        seen = 0;
                        gone = 1;
                    end
                end
            end else begin
                if (seen) begin
                    chk("valid_held", sb[0].id, {63'b0, dif.div_out_valid}, 64'd1);
                    seen = 0;
                end
                dif.div_out_ready = 1'b0;
            end
        end
    end

    // Present one request; returns the cycle index in which it was presented
    task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output int acc);
        int t = 0;
        while (!dif.div_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", n_sent, {63'b0, dif.div_ready}, 64'd1);
        dif.div_valid_in = 1'b1;
        dif.div_op       = op;
        dif.div_src1     = a;
        dif.div_src2     = b;
        acc = cyc;
        n_sent++;
        @(negedge clk);
        dif.div_valid_in = 1'b0;
    endtask

    task automatic push(input logic [63:0] exp, input int lat, input int acc, input int hold);
        exp_t e;
        e.exp  = exp;
        e.lat  = lat;
        e.acc  = acc;
        e.hold = hold;
        e.id   = n_sent - 1;
        sb.push_back(e);
    endtask

    task automatic directed(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            input int hold, input logic [63:0] exp, input int lat);
        int acc;
        drive(op, a, b, acc);
        push(exp, lat, acc, hold);
    endtask

    task automatic random_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        int          acc, lat;
        logic [63:0] exp;
        ref_model(op, a, b, exp, lat);
        drive(op, a, b, acc);
        push(exp, lat, acc, hold);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !dif.div_ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 0, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic [2:0]  op;
        logic [63:0] a, b;
        rst              = 1'b1;
        dif.div_valid_in = 1'b0;
        dif.div_op       = 3'b000;
        dif.div_src1     = 64'h0;
        dif.div_src2     = 64'h0;
        dif.div_flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, {63'b0, dif.div_ready}, 64'd1);
        chk("rst_valid", 0, {63'b0, dif.div_out_valid}, 64'd0);
        chk("rst_busy",  0, {63'b0, dif.div_busy}, 64'd0);
        chk("rst_out",   0, dif.div_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with fixed expected values
        directed(3'b000, 64'd100, 64'd7, 0, 64'd14, 65);
        directed(3'b010, 64'd100, 64'd7, 0, 64'd2, 65);
        directed(3'b001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        directed(3'b011, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        directed(3'b001, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        directed(3'b111, 64'h0000_0000_8000_0001, 64'd0, 0, 64'hFFFF_FFFF_8000_0001, 1);
        directed(3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1);
        directed(3'b111, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'd0, 1);
        directed(3'b100, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        drain();

        // Flush 10 cycles into a DIVU: no result may appear
        drive(3'b000, 64'd1000, 64'd3, acc);
        repeat (9) @(negedge clk);
        dif.div_flush = 1'b1;
        @(negedge clk);
        dif.div_flush = 1'b0;
        chk("flush_busy",  1, {63'b0, dif.div_busy}, 64'd0);
        chk("flush_ready", 1, {63'b0, dif.div_ready}, 64'd1);
        repeat (80) @(negedge clk);

        // Request coinciding with flush in IDLE is not accepted
        dif.div_valid_in = 1'b1;
        dif.div_op       = 3'b000;
        dif.div_src1     = 64'd50;
        dif.div_src2     = 64'd5;
        dif.div_flush    = 1'b1;
        @(negedge clk);
        dif.div_valid_in = 1'b0;
        dif.div_flush    = 1'b0;
        chk("flush_accept_busy", 2, {63'b0, dif.div_busy}, 64'd0);

        // Post-flush op with 5 cycles of backpressure
        directed(3'b000, 64'd9, 64'd3, 5, 64'd3, 65);
        drain();

        // Asynchronous reset mid-operation
        drive(3'b001, 64'd12345, 64'd17, acc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",  3, {63'b0, dif.div_busy}, 64'd0);
        chk("midrst_valid", 3, {63'b0, dif.div_out_valid}, 64'd0);
        chk("midrst_out",   3, dif.div_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 40)); end
                1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
                2: begin a = {$urandom, $urandom}; b = 64'h0; end
                3: begin
                    a = op[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = op[2] ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                4: begin a = {$urandom, $urandom}; b = 64'($urandom_range(1, 255)); end
                default: begin a = {32'hFFFF_FFFF, $urandom}; b = {32'hFFFF_FFFF, 32'($urandom_range(1, 99999))}; end
            endcase
            random_op(op, a, b, int'($urandom_range(0, 2)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
